// File: rtl/mmio_store_capture.sv
// Captures processor stores into a 256-byte MMIO window and queues them in a first-word-fall-through FIFO.
// Define CAPTURE_TIMESTAMP_EN to tag each entry with a 16-bit cycle count, presented on out_tstamp.
module mmio_store_capture #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_ADDR = 32'h0000_050C,
    parameter logic [31:0] PASS_DATA = 32'hFFFF_FAF3
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAddress,
    input  logic [31:0]                WriteData,
    input  logic                       overflow,
    input  logic                       underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_addr,
    output logic [31:0]                out_data,
    output logic                       out_ovf,
    output logic                       out_udf,
`ifdef CAPTURE_TIMESTAMP_EN
    output logic [15:0]                out_tstamp,
`endif
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_cnt,
    output logic                       pass_seen
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
`ifdef CAPTURE_TIMESTAMP_EN
    localparam int ENTRY_W = 58;
`else
    localparam int ENTRY_W = 42;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [LVL_W-1:0]   level_next;
    logic [15:0]        drop_cnt_reg;
    logic               pass_seen_reg;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               hit;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               pass_hit;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [15:0] tstamp_reg;
    // An entry carries the counter value that becomes current at its push edge.
    assign push_entry = {tstamp_reg + 16'd1, DataAddress[7:0], WriteData, overflow, underflow};
`else
    assign push_entry = {DataAddress[7:0], WriteData, overflow, underflow};
`endif

    assign hit      = MemWrite && (DataAddress[31:8] == BASE_ADDR[31:8]);
    assign full     = (level_reg == LVL_W'(DEPTH));
    assign out_valid = (level_reg != '0);
    assign pop      = out_valid && out_ready;
    // A full FIFO still takes a store when the head leaves in the same cycle.
    assign push     = hit && (!full || pop);
    assign drop     = hit && full && !pop;
    assign pass_hit = MemWrite && (DataAddress == PASS_ADDR) && (WriteData == PASS_DATA);

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            drop_cnt_reg  <= '0;
            pass_seen_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg <= level_next;
            if (drop && (drop_cnt_reg != 16'hFFFF))
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            if (pass_hit)
                pass_seen_reg <= 1'b1;
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (!Reset)
            tstamp_reg <= '0;
        else
            tstamp_reg <= tstamp_reg + 16'd1;
    end
`endif

    // Storage is never cleared; a stale slot is unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= push_entry;
    end

    assign head_entry = mem[rd_ptr_reg];

    assign out_addr  = out_valid ? head_entry[41:34] : 8'd0;
    assign out_data  = out_valid ? head_entry[33:2]  : 32'd0;
    assign out_ovf   = out_valid ? head_entry[1]     : 1'b0;
    assign out_udf   = out_valid ? head_entry[0]     : 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
    assign out_tstamp = out_valid ? head_entry[57:42] : 16'd0;
`endif

    assign level     = level_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign pass_seen = pass_seen_reg;

endmodule

// File: doc/mmio_store_capture.md
MMIO_STORE_CAPTURE -- requirements
Module: mmio_store_capture

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0500, the 256-byte-aligned base of the capture window.
REQ-002 The block SHALL have parameter DEPTH, default 8, the FIFO entry count, a power of two from 2 to 64.
REQ-003 The block SHALL have parameter PASS_ADDR, default 32'h0000_050C, the pass-signature store address.
REQ-004 The block SHALL have parameter PASS_DATA, default 32'hFFFF_FAF3, the pass-signature store data.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit, the reset, which is synchronous and active-low.
REQ-007 The block SHALL have port MemWrite, input, 1 bit, the processor store strobe.
REQ-008 The block SHALL have port DataAddress, input, 32 bits, the processor store address.
REQ-009 The block SHALL have port WriteData, input, 32 bits, the processor store data.
REQ-010 The block SHALL have ports overflow and underflow, input, 1 bit each, the processor ALU flags sampled with each store.
REQ-011 The block SHALL have port out_valid, output, 1 bit, asserted when the FIFO head entry is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the consumer accept signal.
REQ-013 The block SHALL have port out_addr, output, 8 bits, the head entry address offset within the window.
REQ-014 The block SHALL have port out_data, output, 32 bits, the head entry data.
REQ-015 The block SHALL have ports out_ovf and out_udf, output, 1 bit each, the head entry captured flags.
REQ-016 The block SHALL have port level, output, clog2(DEPTH)+1 bits, the current FIFO occupancy.
REQ-017 The block SHALL have port drop_cnt, output, 16 bits, the count of in-window stores lost while the FIFO was full.
REQ-018 The block SHALL have port pass_seen, output, 1 bit, a sticky flag set by a pass-signature store.

Function
REQ-019 The block SHALL define hit as MemWrite AND DataAddress[31:8] equal to BASE_ADDR[31:8].
REQ-020 The block SHALL push {DataAddress[7:0], WriteData, overflow, underflow} on a clock edge where hit is true and level is less than DEPTH.
REQ-021 The block SHALL also push when hit is true, level equals DEPTH and a pop occurs in the same cycle; level SHALL then be unchanged.
REQ-022 The block SHALL, when hit is true, level equals DEPTH and no pop occurs, drop the store and increment drop_cnt, saturating at 16'hFFFF.
REQ-023 The FIFO SHALL be first-word-fall-through: a pushed entry SHALL appear on the out_* ports in the cycle after the push edge, with a latency of one cycle.
REQ-024 A pop SHALL occur on a clock edge where out_valid AND out_ready are both true; out_valid SHALL equal (level != 0).
REQ-025 The block SHALL, on a simultaneous push and pop, perform both, leave level unchanged and preserve ordering.
REQ-026 The block SHALL, on a push into an empty FIFO with out_ready high, perform no pop in that cycle.
REQ-027 The block SHALL drive out_addr, out_data, out_ovf and out_udf to 0 whenever out_valid is 0.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 The block SHALL set pass_seen one edge after MemWrite is seen with DataAddress equal to PASS_ADDR and WriteData equal to PASS_DATA, whether or not the address is in the window and whether or not the FIFO is full; pass_seen SHALL clear only on reset.
REQ-030 The block SHALL ignore stores with MemWrite low; it SHALL push nothing and leave all counters unchanged.

Reset
REQ-031 When Reset is 0 at a rising edge, the block SHALL clear both pointers, level, drop_cnt, pass_seen and the timestamp counter.
REQ-032 The block SHALL not reset FIFO storage; outputs SHALL still read 0 per REQ-027.
REQ-033 Reset SHALL take priority over a simultaneous push or pop; all entries in flight SHALL be discarded.
REQ-034 In the first cycle after Reset returns to 1, out_valid SHALL be 0 and pushes SHALL be accepted normally.

Configuration
REQ-035 With macro CAPTURE_TIMESTAMP_EN defined, the block SHALL keep a free-running 16-bit cycle counter that is reset to 0 and wraps at 16'hFFFF.
REQ-036 With CAPTURE_TIMESTAMP_EN defined, each entry SHALL store the counter value at its push edge, presented on an added output out_tstamp (16 bits) that reads 0 when out_valid is 0.
REQ-037 Without CAPTURE_TIMESTAMP_EN, the block SHALL have no counter and no out_tstamp port, and all other behaviour SHALL be identical.

Verification
REQ-038 Scenario: store to 0x504 with data 0x11, out_ready=0 -> next cycle out_valid=1, out_addr=0x04, out_data=0x11, level=1.
REQ-039 Scenario: 10 consecutive in-window stores with out_ready=0 and DEPTH=8 -> level=8, drop_cnt=2, and pops return the first 8 stores in order.
REQ-040 Scenario: FIFO full with out_ready=1 and an in-window store in the same cycle -> level stays 8, drop_cnt is unchanged, and the new entry is popped last.
REQ-041 Scenario: store to 0x600 and store with MemWrite=0 -> level=0, drop_cnt=0.
REQ-042 Scenario: store 0xFFFFFAF3 to 0x50C while full -> pass_seen=1 next cycle, drop_cnt increments, and pass_seen holds until Reset=0.
REQ-043 Scenario: Reset=0 with 3 entries queued and out_ready=1 -> after the edge, level=0, out_valid=0, out_data=0; with CAPTURE_TIMESTAMP_EN, the first store after reset release carries out_tstamp=1.
